alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
// - Multi-cycle successor to the combinational ALU: full RV32I register-register op set
//   plus RV32M multiply/divide, behind valid/ready handshakes on input and output.
// - Base ops complete in 1 cycle; MUL*/DIV*/REM* run on an iterative radix-2 engine.
// - Sits in the execute stage between operand read and writeback; one op in flight at a time.
// PARAMETERS
// - WIDTH      32  operand/result width; power of two, >= 4
// - MULDIV_EN  1   1: RV32M ops execute; 0: RV32M ops return 0 after 1 cycle
// PORTS
// - clk        in   1      clock; all state updates on rising edge
// - rst        in   1      asynchronous, active-high reset
// - in_valid   in   1      op presented on fn/funct7/a/b
// - in_ready   out  1      unit can accept; op accepted when in_valid && in_ready
// - fn         in   3      alu_fn_t (funct3 encoding)
// - funct7     in   7      funct7_t: 0000000 base, 0100000 SUB/SRA, 0000001 MULDIV
// - a, b       in   WIDTH  rs1, rs2 operands
// - out_valid  out  1      result valid; held until out_ready
// - out_ready  in   1      consumer takes result when out_valid && out_ready
// - result     out  WIDTH  result; stable while out_valid && !out_ready
// BEHAVIOUR
// - Reset (async, any state): state=IDLE, in_ready=1, out_valid=0, result=0, engine regs 0.
// - FSM: IDLE -> (accept base op) DONE; IDLE -> (accept MULDIV op) BUSY or DONE (special
//   case); BUSY -> FIX after WIDTH iterations; FIX -> DONE; DONE -> IDLE when out_ready.
// - in_ready = (state==IDLE). Operands latched on accept; inputs ignored outside IDLE.
// - out_valid = (state==DONE). No accept in the same cycle as result pop.
// - Latency accept->out_valid: base ops 1 cycle; MULDIV WIDTH+2 cycles; div-by-0/overflow 1.
// - Base ops (funct7 != MULDIV): ADD/SUB (SUB iff funct7==0100000), SLL, SRL/SRA (SRA iff
//   0100000, arithmetic on signed a), XOR, OR, AND; shift amount = b[$clog2(WIDTH)-1:0].
// - SLT = {0.., $signed(a)<$signed(b)}; SLTU = {0.., a<b} unsigned. Wrap-around on ADD/SUB.
// - fn for MULDIV: 000 MUL (low half), 001 MULH (s*s high), 010 MULHSU (s*u high),
//   011 MULHU (u*u high), 100 DIV, 101 DIVU, 110 REM, 111 REMU.
// - Engine: operate on magnitudes of signed operands; shift-add multiply to 2*WIDTH product,
//   restoring divide to quotient/remainder, one bit per cycle; FIX negates per sign rules
//   (product negated iff signs differ; quotient iff signs differ; remainder takes sign of a).
// - Div by zero (b==0): DIV/DIVU quotient = all ones; REM/REMU = a. Skips BUSY.
// - Signed overflow (a==MIN, b==-1): DIV = MIN, REM = 0. Skips BUSY.
// - Unused funct7 values: treated as 0000000. Reset mid-BUSY aborts op, no result emitted.
// - MULDIV_EN=0: MULDIV ops go IDLE->DONE with result 0; engine not instantiated.
// TESTING (WIDTH=32)
// - ADD 7+(-3)=4; SUB 0-1=FFFFFFFF; SRA 80000000>>>4=F8000000; SRL 80000000>>4=08000000;
//   each out_valid exactly 1 cycle after accept.
// - SLT a=FFFFFFFF,b=1 -> 1; SLTU same -> 0; SLL shamt b=0x21 -> shift by 1.
// - MUL 0xFFFFFFFF*0xFFFFFFFF: MUL=1, MULH=0, MULHU=FFFFFFFE, MULHSU=FFFFFFFF; out_valid at
//   cycle 34 after accept; in_ready low throughout.
// - DIV -7/2 -> FFFFFFFD, REM -7/2 -> FFFFFFFF; DIVU 5/0 -> FFFFFFFF, REMU 5/0 -> 5;
//   DIV 80000000/FFFFFFFF -> 80000000, REM -> 0 (latency 1).
// - Backpressure: out_ready=0 for 5 cycles after result -> result/out_valid stable, in_ready
//   low; raise out_ready -> next cycle in_ready=1.
// - Assert rst mid-BUSY (async, between edges) -> out_valid=0, in_ready=1 immediately; next op correct.

Source files
------------

// File: rtl/alu_seq.sv
// Execute-stage ALU: RV32I register-register ops in one cycle, RV32M ops on an iterative
// radix-2 shift-add / restoring-divide engine, valid/ready on both sides, one op in flight.
module alu_seq #(
    parameter int unsigned WIDTH     = 32,
    parameter bit          MULDIV_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       fn,
    input  logic [6:0]       funct7,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned SHW  = $clog2(WIDTH);
    localparam int unsigned CNTW = $clog2(WIDTH);
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIX, S_DONE} state_t;

    state_t             state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [2:0]         fn_q, fn_d;
    logic               neg_q, neg_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [CNTW-1:0]    cnt_q, cnt_d;

    logic [SHW-1:0]     shamt;
    logic               alt;
    logic [WIDTH-1:0]   alu_res;
    logic               sign_a, sign_b, neg_init;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic               div_zero, div_ovf;
    logic [WIDTH-1:0]   special_res;
    logic [WIDTH:0]     mul_sum, div_rem;
    logic [WIDTH-1:0]   div_sub;
    logic               div_ge;
    logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix, fix_res;

    // Single-cycle base operations
    always_comb begin
        shamt   = b[SHW-1:0];
        alt     = (funct7 == F7_ALT);
        alu_res = '0;
        case (fn)
            3'b000:  alu_res = alt ? (a - b) : (a + b);
            3'b001:  alu_res = a << shamt;
            3'b010:  alu_res = WIDTH'($signed(a) < $signed(b));
            3'b011:  alu_res = WIDTH'(a < b);
            3'b100:  alu_res = a ^ b;
            3'b101:  alu_res = alt ? WIDTH'($signed(a) >>> shamt) : (a >> shamt);
            3'b110:  alu_res = a | b;
            default: alu_res = a & b;
        endcase
    end

    // Operand signedness, magnitudes and the sign to restore in FIX
    always_comb begin
        sign_a   = 1'b0;
        sign_b   = 1'b0;
        neg_init = 1'b0;
        case (fn)
            3'b000, 3'b001, 3'b100: begin
                sign_a   = a[WIDTH-1];
                sign_b   = b[WIDTH-1];
                neg_init = a[WIDTH-1] ^ b[WIDTH-1];
            end
            3'b010, 3'b110: begin
                sign_a   = a[WIDTH-1];
                sign_b   = (fn == 3'b110) ? b[WIDTH-1] : 1'b0;
                neg_init = a[WIDTH-1];
            end
            default: ;
        endcase
        mag_a       = sign_a ? -a : a;
        mag_b       = sign_b ? -b : b;
        div_zero    = fn[2] && (b == '0);
        div_ovf     = (fn == 3'b100 || fn == 3'b110) && (a == MIN_VAL) && (b == '1);
        special_res = div_zero ? (fn[1] ? a : '1) : (fn[1] ? '0 : MIN_VAL);
    end

    // One engine iteration and the final sign fix-up
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};
        div_rem  = acc_q[2*WIDTH-1:WIDTH-1];
        div_ge   = (div_rem >= {1'b0, opnd_q});
        div_sub  = WIDTH'(div_rem - {1'b0, opnd_q});
        div_next = {div_ge ? div_sub : div_rem[WIDTH-1:0], acc_q[WIDTH-2:0], div_ge};
        prod_fix = neg_q ? -acc_q : acc_q;
        quo_fix  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        case (fn_q)
            3'b000:                 fix_res = prod_fix[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         fix_res = quo_fix;
            default:                fix_res = rem_fix;
        endcase
    end

    // Control: next state and registered outputs
    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        fn_d        = fn_q;
        neg_d       = neg_q;
        acc_d       = acc_q;
        opnd_d      = opnd_q;
        cnt_d       = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    in_ready_d  = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                    if (funct7 != F7_MULDIV) begin
                        result_d = alu_res;
                    end else if (!MULDIV_EN) begin
                        result_d = '0;
                    end else if (div_zero || div_ovf) begin
                        result_d = special_res;
                    end else begin
                        out_valid_d = 1'b0;
                        state_d     = S_BUSY;
                        fn_d        = fn;
                        neg_d       = neg_init;
                        cnt_d       = '0;
                        acc_d       = {{WIDTH{1'b0}}, fn[2] ? mag_a : mag_b};
                        opnd_d      = fn[2] ? mag_b : mag_a;
                    end
                end
            end
            S_BUSY: begin
                acc_d = fn_q[2] ? div_next : mul_next;
                cnt_d = cnt_q + CNTW'(1);
                if (cnt_q == CNTW'(WIDTH - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                result_d    = fix_res;
                out_valid_d = 1'b1;
                state_d     = S_DONE;
            end
            default: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            fn_q        <= '0;
            neg_q       <= 1'b0;
            acc_q       <= '0;
            opnd_q      <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            fn_q        <= fn_d;
            neg_q       <= neg_d;
            acc_q       <= acc_d;
            opnd_q      <= opnd_d;
            cnt_q       <= cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule

// File: tb/tb_alu_seq.sv
// Randomized and directed bench for alu_seq against a 64-bit arithmetic reference model.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  fn;
    logic [6:0]  funct7;
    logic [31:0] a, b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(32), .MULDIV_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .fn(fn), .funct7(funct7), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [6:0] f7,
                                            input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy, uy, p;
        logic [63:0] pu;
        logic [4:0]  sh;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        uy = {32'd0, y};
        pu = {32'd0, x} * {32'd0, y};
        sh = y[4:0];
        if (f7 == 7'h01) begin
            case (f)
                3'd0: begin p = sx * sy; return p[31:0]; end
                3'd1: begin p = sx * sy; return p[63:32]; end
                3'd2: begin p = sx * uy; return p[63:32]; end
                3'd3: return pu[63:32];
                3'd4: begin
                    if (y == 0) return 32'hFFFF_FFFF;
                    if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
                    p = sx / sy; return p[31:0];
                end
                3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
                3'd6: begin
                    if (y == 0) return x;
                    if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
                    p = sx % sy; return p[31:0];
                end
                default: return (y == 0) ? x : x % y;
            endcase
        end
        case (f)
            3'd0: return (f7 == 7'h20) ? x - y : x + y;
            3'd1: return x << sh;
            3'd2: return (sx < sy) ? 32'd1 : 32'd0;
            3'd3: return (x < y) ? 32'd1 : 32'd0;
            3'd4: return x ^ y;
            3'd5: return (f7 == 7'h20) ? 32'(sx >> sh) : x >> sh;
            3'd6: return x | y;
            default: return x & y;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f, input logic [6:0] f7,
                                   input logic [31:0] x, input logic [31:0] y);
        if (f7 != 7'h01) return 1;
        if (f[2] && y == 0) return 1;
        if ((f == 3'd4 || f == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    task automatic run_op(input string tag, input logic [2:0] f, input logic [6:0] f7,
                          input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] exp_res, input int hold);
        int          n;
        int          lat;
        logic        busy_bad;
        logic        hold_bad;
        logic [31:0] res0;
        fn = f; funct7 = f7; a = x; b = y; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        fn = 3'($urandom); funct7 = 7'($urandom); a = $urandom; b = $urandom;
        lat = 1;
        busy_bad = 1'b0;
        while (!out_valid && lat < 100) begin
            if (in_ready) busy_bad = 1'b1;
            @(posedge clk); #1; lat++;
        end
        chk({tag, ".lat"}, 64'(lat), 64'(ref_lat(f, f7, x, y)));
        chk({tag, ".busy_rdy"}, {63'd0, busy_bad | in_ready}, 64'd0);
        chk({tag, ".res"}, {32'd0, result}, {32'd0, exp_res});
        res0 = result;
        hold_bad = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || result !== res0 || in_ready !== 1'b0) hold_bad = 1'b1;
        end
        chk({tag, ".hold"}, {63'd0, hold_bad}, 64'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, ".pop"}, {62'd0, in_ready, out_valid}, 64'd2);
    endtask

    function automatic logic [31:0] pick_opnd();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [2:0]  rf;
        logic [6:0]  rf7;
        logic [31:0] ra, rb;
        int          seen;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        fn = '0; funct7 = '0; a = '0; b = '0;
        #2;
        chk("reset", {61'd0, in_ready, out_valid, |result}, 64'd4);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        run_op("add",    3'd0, 7'h00, 32'd7,          32'hFFFF_FFFD, 32'd4,          0);
        run_op("sub",    3'd0, 7'h20, 32'd0,          32'd1,         32'hFFFF_FFFF,  0);
        run_op("sra",    3'd5, 7'h20, 32'h8000_0000,  32'd4,         32'hF800_0000,  0);
        run_op("srl",    3'd5, 7'h00, 32'h8000_0000,  32'd4,         32'h0800_0000,  0);
        run_op("slt",    3'd2, 7'h00, 32'hFFFF_FFFF,  32'd1,         32'd1,          0);
        run_op("sltu",   3'd3, 7'h00, 32'hFFFF_FFFF,  32'd1,         32'd0,          0);
        run_op("sll",    3'd1, 7'h00, 32'h8000_0001,  32'h21,        32'd2,          0);
        run_op("f7odd",  3'd0, 7'h55, 32'd10,         32'd3,         32'd13,         0);
        run_op("mul",    3'd0, 7'h01, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd1,          0);
        run_op("mulh",   3'd1, 7'h01, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd0,          0);
        run_op("mulhu",  3'd3, 7'h01, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE,  0);
        run_op("mulhsu", 3'd2, 7'h01, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF,  0);
        run_op("div",    3'd4, 7'h01, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD,  0);
        run_op("rem",    3'd6, 7'h01, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF,  0);
        run_op("divu0",  3'd5, 7'h01, 32'd5,          32'd0,         32'hFFFF_FFFF,  0);
        run_op("remu0",  3'd7, 7'h01, 32'd5,          32'd0,         32'd5,          0);
        run_op("divovf", 3'd4, 7'h01, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000,  0);
        run_op("removf", 3'd6, 7'h01, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,          0);
        run_op("bp",     3'd0, 7'h00, 32'd100,        32'd23,        32'd123,        5);

        // Reset landing between edges in the middle of a multiply
        fn = 3'd0; funct7 = 7'h01; a = 32'd12345; b = 32'd678; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_busy", {62'd0, in_ready, out_valid}, 64'd2);
        rst = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("rst_noresult", 64'(seen), 64'd0);
        run_op("after_rst", 3'd0, 7'h01, 32'd12345, 32'd678, 32'd8369910, 0);

        for (int i = 0; i < 200; i++) begin
            rf = 3'($urandom);
            case ($urandom_range(0, 3))
                0: rf7 = 7'h00;
                1: rf7 = 7'h20;
                2: rf7 = 7'h01;
                default: rf7 = 7'($urandom);
            endcase
            ra = pick_opnd();
            rb = pick_opnd();
            run_op($sformatf("rnd%0d_f%0d_%0h", i, rf, rf7), rf, rf7, ra, rb,
                   ref_res(rf, rf7, ra, rb), $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
